// File: rtl/ascon_data_if_pkg.sv
// ascon_data_if_pkg: shared state encoding and constants for the Ascon data interface
package ascon_data_if_pkg;
    localparam int         BLK_WIDTH = 128;
    localparam logic       PH_AD     = 1'b0;
    localparam logic       PH_MSG    = 1'b1;
    localparam logic [7:0] PAD_BYTE  = 8'h80;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AD,
        ST_MSG,
        ST_PAD,
        ST_FINISH
    } state_t;
endpackage

// File: rtl/ascon_pad128.sv
// ascon_pad128: keeps the first vb bytes, places 0x80 at byte vb and zeroes the rest
module ascon_pad128
    import ascon_data_if_pkg::*;
(
    input  logic [BLK_WIDTH-1:0] data,
    input  logic [4:0]           vb,
    output logic [BLK_WIDTH-1:0] padded
);
    // byte 0 sits at the top of the word; vb=16 passes the whole block through
    always_comb begin
        padded = '0;
        for (int i = 0; i < BLK_WIDTH / 8; i++)
            padded[BLK_WIDTH-1-8*i -: 8] = (5'(i) < vb) ? data[BLK_WIDTH-1-8*i -: 8] :
                                           (5'(i) == vb) ? PAD_BYTE : 8'h00;
    end
endmodule

// File: rtl/ascon_data_if.sv
// ascon_data_if: buffers, pads and sequences AD/message blocks for the permutation controller
module ascon_data_if
    import ascon_data_if_pkg::*;
#(
    parameter int pBLK_WIDTH = 128,
    parameter int pVB_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [pBLK_WIDTH-1:0] data_in,
    input  logic                  valid_data_in,
    input  logic                  last_block,
    input  logic [pVB_WIDTH-1:0]  valid_bytes,
    input  logic                  EOT,
    output logic                  read_data,
    output logic                  ready_for_data,
    output logic [pBLK_WIDTH-1:0] blk_data,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic                  blk_phase,
    output logic                  blk_last,
    output logic                  blk_dsep,
    output logic [pVB_WIDTH-1:0]  blk_bytes,
    output logic                  done
);
    state_t                  r_state;
    state_t                  w_nxt;
    logic                    r_full;
    logic                    r_last;
    logic                    r_pad_pend;
    logic                    r_ad_first;
    logic                    r_first_msg;
    logic                    r_phase;
    logic                    r_dsep;
    logic [pBLK_WIDTH-1:0]   r_data;
    logic [pVB_WIDTH-1:0]    r_bytes;
    logic [4:0]              w_vb;
    logic [pBLK_WIDTH-1:0]   w_padded;
    logic                    w_last;
    logic                    w_active;
    logic                    w_start;
    logic                    w_consume;
    logic                    w_empty_ad;

    assign w_vb = (valid_bytes > pVB_WIDTH'(16)) ? 5'd16 : 5'(valid_bytes);

    ascon_pad128 u_pad (
        .data   (data_in),
        .vb     (w_vb),
        .padded (w_padded)
    );

    assign blk_data  = r_data;
    assign blk_valid = r_full;
    assign blk_phase = r_phase;
    assign blk_dsep  = r_dsep;
    assign blk_bytes = r_bytes;
    // a full final block is followed by a pad block, which carries the phase-final marker
    assign blk_last  = r_last && !r_pad_pend;

    // next state, handshakes and the done pulse
    always_comb begin
        w_nxt          = r_state;
        w_active       = (r_state == ST_AD) || (r_state == ST_MSG);
        ready_for_data = w_active && !r_full && !r_pad_pend;
        read_data      = ready_for_data && valid_data_in;
        w_last         = last_block | (last_block & EOT);
        w_empty_ad     = read_data && (r_state == ST_AD) && r_ad_first && last_block && (w_vb == 5'd0);
        w_consume      = r_full && blk_ready;
        w_start        = (r_state == ST_IDLE) && start;
        done           = (r_state == ST_FINISH);
        if (w_start)
            w_nxt = ST_AD;
        else if (w_empty_ad)
            w_nxt = ST_MSG;
        else if (w_consume && r_last)
            w_nxt = r_pad_pend ? ST_PAD : (r_phase == PH_AD) ? ST_MSG : ST_FINISH;
        else if (r_state == ST_FINISH)
            w_nxt = ST_IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_nxt;
    end

    // block buffer: capture, pad-block substitution on consume, and sequence flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full      <= 1'b0;
            r_last      <= 1'b0;
            r_pad_pend  <= 1'b0;
            r_ad_first  <= 1'b0;
            r_first_msg <= 1'b0;
            r_phase     <= PH_AD;
            r_dsep      <= 1'b0;
            r_data      <= '0;
            r_bytes     <= '0;
        end else if (w_start) begin
            r_ad_first  <= 1'b1;
            r_first_msg <= 1'b1;
        end else if (w_consume && r_last && r_pad_pend) begin
            r_data     <= {PAD_BYTE, {(pBLK_WIDTH-8){1'b0}}};
            r_bytes    <= '0;
            r_pad_pend <= 1'b0;
            r_dsep     <= 1'b0;
        end else if (w_consume) begin
            r_full <= 1'b0;
        end else if (w_empty_ad) begin
            r_ad_first <= 1'b0;
        end else if (read_data) begin
            r_full      <= 1'b1;
            r_data      <= w_padded;
            r_bytes     <= pVB_WIDTH'(w_vb);
            r_last      <= w_last;
            r_phase     <= (r_state == ST_MSG) ? PH_MSG : PH_AD;
            r_dsep      <= (r_state == ST_MSG) && r_first_msg;
            r_pad_pend  <= w_last && (w_vb == 5'd16);
            r_ad_first  <= 1'b0;
            r_first_msg <= r_first_msg && (r_state != ST_MSG);
        end
    end
endmodule
